// File: rtl/dram_burst_reader_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : dram_burst_reader_pkg
// Brief  : AXI read constants and FSM state encoding shared by the
//          DRAM burst reader.
// Rev    : 1.0  initial release
// ============================================================================
package dram_burst_reader_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [2:0] ARSIZE_16B = 3'b100;

  // Explicitly encoded so the state register width is fixed.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/dram_burst_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : dram_burst_reader
// Brief  : AXI4 read master. Splits a request (start address + beat count)
//          at 4 KB boundaries into INCR bursts, one outstanding at a time,
//          and streams 128-bit beats to the consumer with back-pressure.
// Rev    : 1.0  initial release
// ============================================================================
module dram_burst_reader
  import dram_burst_reader_pkg::*;
#(
  parameter int DRAM_ADDR_WIDTH = 39,
  parameter int DRAM_DATA_WIDTH = 128
) (
  input  logic                       s_axi_aclk,
  input  logic                       s_axi_aresetn,
  // image controller request/response side
  input  logic [DRAM_ADDR_WIDTH-1:0] dram_read_addr,
  input  logic [7:0]                 dram_read_len,
  input  logic                       dram_read_en,
  input  logic                       dram_buffer_full,
  output logic                       dram_read_busy,
  output logic [DRAM_DATA_WIDTH-1:0] dram_read_data,
  output logic                       dram_read_data_valid,
  output logic                       dram_read_error,
  // AXI AR channel
  output logic [DRAM_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                 m_axi_arlen,
  output logic [2:0]                 m_axi_arsize,
  output logic [1:0]                 m_axi_arburst,
  output logic                       m_axi_arvalid,
  input  logic                       m_axi_arready,
  // AXI R channel
  input  logic [DRAM_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                 m_axi_rresp,
  input  logic                       m_axi_rlast,
  input  logic                       m_axi_rvalid,
  output logic                       m_axi_rready
);

  // arlen of the next burst: the smaller of the beats still owed and the
  // beats left before the next 4 KB line (256 beats of 16 bytes).
  function automatic logic [7:0] split_arlen(input logic [7:0] line_idx,
                                             input logic [8:0] remaining);
    logic [8:0] room;
    logic [8:0] beats;
    room  = 9'd256 - {1'b0, line_idx};
    beats = (remaining < room) ? remaining : room;
    return 8'(beats - 9'd1);
  endfunction

  state_e                     state_q,   state_d;
  logic [DRAM_ADDR_WIDTH-1:0] addr_q,    addr_d;     // start of next unissued beat
  logic [8:0]                 total_q,   total_d;    // beats not yet requested on AR
  logic [7:0]                 beat_cnt_q, beat_cnt_d; // beats left in current burst, minus one
  logic                       busy_q,    busy_d;
  logic [DRAM_DATA_WIDTH-1:0] data_q,    data_d;
  logic                       valid_q,   valid_d;
  logic                       error_q,   error_d;
  logic                       arvalid_q, arvalid_d;
  logic [DRAM_ADDR_WIDTH-1:0] araddr_q,  araddr_d;
  logic [7:0]                 arlen_q,   arlen_d;

  logic [DRAM_ADDR_WIDTH-1:0] req_addr;
  logic [8:0]                 req_total;
  logic [7:0]                 split_line;
  logic [8:0]                 split_total;
  logic [7:0]                 next_arlen;
  logic [8:0]                 ar_beats;
  logic                       ar_hs;
  logic                       r_hs;
  logic                       last_beat;
  logic                       rready;
  logic                       unused_addr_lsbs;

  // Beat-aligned request address; the byte offset inside a beat is dropped.
  assign req_addr         = {dram_read_addr[DRAM_ADDR_WIDTH-1:4], 4'b0000};
  assign unused_addr_lsbs = ^dram_read_addr[3:0];
  assign req_total        = {1'b0, dram_read_len} + 9'd1;

  // The split is evaluated on the incoming request from IDLE and on the
  // running address/remainder when chaining the next burst from DATA.
  assign split_line  = (state_q == ST_IDLE) ? dram_read_addr[11:4] : addr_q[11:4];
  assign split_total = (state_q == ST_IDLE) ? req_total : total_q;
  assign next_arlen  = split_arlen(split_line, split_total);

  assign ar_beats  = {1'b0, arlen_q} + 9'd1;
  assign ar_hs     = arvalid_q & m_axi_arready;
  assign rready    = (state_q == ST_DATA) & ~dram_buffer_full;
  assign r_hs      = rready & m_axi_rvalid;
  assign last_beat = (beat_cnt_q == 8'd0);

  // Next-state logic for the request FSM and all registered outputs.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    total_d    = total_q;
    beat_cnt_d = beat_cnt_q;
    busy_d     = busy_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    error_d    = error_q;
    arvalid_d  = arvalid_q;
    araddr_d   = araddr_q;
    arlen_d    = arlen_q;

    case (state_q)
      ST_IDLE: begin
        if (dram_read_en) begin
          addr_d    = req_addr;
          total_d   = req_total;
          busy_d    = 1'b1;
          error_d   = 1'b0;
          arvalid_d = 1'b1;
          araddr_d  = req_addr;
          arlen_d   = next_arlen;
          state_d   = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (ar_hs) begin
          addr_d     = addr_q + {{(DRAM_ADDR_WIDTH-13){1'b0}}, ar_beats, 4'b0000};
          total_d    = total_q - ar_beats;
          beat_cnt_d = arlen_q;
          arvalid_d  = 1'b0;
          state_d    = ST_DATA;
        end
      end
      ST_DATA: begin
        if (r_hs) begin
          data_d     = m_axi_rdata;
          valid_d    = 1'b1;
          beat_cnt_d = beat_cnt_q - 8'd1;
          if ((m_axi_rresp != RESP_OKAY) || (m_axi_rlast != last_beat)) begin
            error_d = 1'b1;
          end
          // The burst ends on our own count, so an early or missing rlast
          // only flags an error and never desynchronises the split.
          if (last_beat) begin
            if (total_q != 9'd0) begin
              arvalid_d = 1'b1;
              araddr_d  = addr_q;
              arlen_d   = next_arlen;
              state_d   = ST_ADDR;
            end else begin
              busy_d  = 1'b0;
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      total_q    <= '0;
      beat_cnt_q <= '0;
      busy_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
      arvalid_q  <= 1'b0;
      araddr_q   <= '0;
      arlen_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      total_q    <= total_d;
      beat_cnt_q <= beat_cnt_d;
      busy_q     <= busy_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
      arvalid_q  <= arvalid_d;
      araddr_q   <= araddr_d;
      arlen_q    <= arlen_d;
    end
  end

  assign dram_read_busy       = busy_q;
  assign dram_read_data       = data_q;
  assign dram_read_data_valid = valid_q;
  assign dram_read_error      = error_q;
  assign m_axi_araddr         = araddr_q;
  assign m_axi_arlen          = arlen_q;
  assign m_axi_arsize         = ARSIZE_16B;
  assign m_axi_arburst        = BURST_INCR;
  assign m_axi_arvalid        = arvalid_q;
  assign m_axi_rready         = rready;

endmodule
`default_nettype wire

// File: tb/tb_dram_burst_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_dram_burst_reader
// Brief  : Directed self-checking bench for dram_burst_reader with a small
//          AXI read slave whose beat data equals the beat byte address.
// Rev    : 1.0  initial release
// ============================================================================
module tb_dram_burst_reader;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [38:0]  dram_read_addr;
  logic [7:0]   dram_read_len;
  logic         dram_read_en;
  logic         dram_buffer_full;
  logic         dram_read_busy;
  logic [127:0] dram_read_data;
  logic         dram_read_data_valid;
  logic         dram_read_error;
  logic [38:0]  m_axi_araddr;
  logic [7:0]   m_axi_arlen;
  logic [2:0]   m_axi_arsize;
  logic [1:0]   m_axi_arburst;
  logic         m_axi_arvalid;
  logic         m_axi_arready;
  logic [127:0] m_axi_rdata;
  logic [1:0]   m_axi_rresp;
  logic         m_axi_rlast;
  logic         m_axi_rvalid;
  logic         m_axi_rready;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int fall_cyc = -1;
  logic prev_busy;

  logic [127:0] obs_data[$];
  int           obs_cyc[$];
  logic [38:0]  obs_araddr[$];
  logic [7:0]   obs_arlen[$];

  // slave state and fault injection (beat index inside a burst, -1 = off)
  logic [38:0]  sl_addr_q[$];
  logic [7:0]   sl_len_q[$];
  int           sl_beat = 0;
  int           inj_err_beat = -1;
  int           inj_rlast_beat = -1;
  logic         sl_ar_hs, sl_r_hs;
  logic [38:0]  sl_ar_addr;
  logic [7:0]   sl_ar_len;

  dram_burst_reader #(
    .DRAM_ADDR_WIDTH(39),
    .DRAM_DATA_WIDTH(128)
  ) dut (
    .s_axi_aclk          (clk),
    .s_axi_aresetn       (rst_n),
    .dram_read_addr      (dram_read_addr),
    .dram_read_len       (dram_read_len),
    .dram_read_en        (dram_read_en),
    .dram_buffer_full    (dram_buffer_full),
    .dram_read_busy      (dram_read_busy),
    .dram_read_data      (dram_read_data),
    .dram_read_data_valid(dram_read_data_valid),
    .dram_read_error     (dram_read_error),
    .m_axi_araddr        (m_axi_araddr),
    .m_axi_arlen         (m_axi_arlen),
    .m_axi_arsize        (m_axi_arsize),
    .m_axi_arburst       (m_axi_arburst),
    .m_axi_arvalid       (m_axi_arvalid),
    .m_axi_arready       (m_axi_arready),
    .m_axi_rdata         (m_axi_rdata),
    .m_axi_rresp         (m_axi_rresp),
    .m_axi_rlast         (m_axi_rlast),
    .m_axi_rvalid        (m_axi_rvalid),
    .m_axi_rready        (m_axi_rready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observer: records delivered beats, AR handshakes and the busy fall time.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (dram_read_data_valid) begin
        obs_data.push_back(dram_read_data);
        obs_cyc.push_back(cyc);
      end
      if (m_axi_arvalid && m_axi_arready) begin
        obs_araddr.push_back(m_axi_araddr);
        obs_arlen.push_back(m_axi_arlen);
      end
      if (prev_busy === 1'b1 && dram_read_busy === 1'b0) fall_cyc = cyc;
    end
    prev_busy = dram_read_busy;
  end

  // AXI read slave: samples handshakes mid-cycle, updates its outputs
  // shortly after the following rising edge. One burst returned at a time.
  always begin
    @(negedge clk);
    sl_ar_hs   = m_axi_arvalid && m_axi_arready;
    sl_r_hs    = m_axi_rvalid && m_axi_rready;
    sl_ar_addr = m_axi_araddr;
    sl_ar_len  = m_axi_arlen;
    @(posedge clk);
    #2;
    if (rst_n !== 1'b1) begin
      sl_addr_q.delete();
      sl_len_q.delete();
      sl_beat      = 0;
      m_axi_rvalid = 1'b0;
      m_axi_rlast  = 1'b0;
      m_axi_rresp  = 2'b00;
      m_axi_rdata  = '0;
    end else begin
      if (sl_ar_hs) begin
        sl_addr_q.push_back(sl_ar_addr);
        sl_len_q.push_back(sl_ar_len);
      end
      if (sl_r_hs && sl_len_q.size() > 0) begin
        if (sl_beat == int'(sl_len_q[0])) begin
          void'(sl_addr_q.pop_front());
          void'(sl_len_q.pop_front());
          sl_beat = 0;
        end else begin
          sl_beat++;
        end
      end
      if (sl_len_q.size() > 0) begin
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = 128'(sl_addr_q[0] + 39'(sl_beat) * 39'd16);
        m_axi_rresp  = (sl_beat == inj_err_beat) ? 2'b10 : 2'b00;
        m_axi_rlast  = (sl_beat == int'(sl_len_q[0])) || (sl_beat == inj_rlast_beat);
      end else begin
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        m_axi_rresp  = 2'b00;
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    obs_data.delete();
    obs_cyc.delete();
    obs_araddr.delete();
    obs_arlen.delete();
    fall_cyc = -1;
  endtask

  // Drives a one-cycle request; returns just after the accepting edge.
  task automatic issue(input logic [38:0] a, input logic [7:0] l);
    @(posedge clk); #1;
    dram_read_addr = a;
    dram_read_len  = l;
    dram_read_en   = 1'b1;
    @(posedge clk); #1;
    dram_read_en   = 1'b0;
  endtask

  task automatic wait_done(input int max);
    int n = 0;
    @(negedge clk);
    while (dram_read_busy !== 1'b0 && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", 128'(n >= max), 128'(0));
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic wait_valids(input int cnt, input int max);
    int k = 0;
    while (obs_data.size() < cnt && k < max) begin
      @(negedge clk); #1;
      k++;
    end
    chk("valid_timeout", 128'(k >= max), 128'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst_n            = 1'b0;
    dram_read_addr   = '0;
    dram_read_len    = '0;
    dram_read_en     = 1'b0;
    dram_buffer_full = 1'b0;
    m_axi_arready    = 1'b1;
    m_axi_rvalid     = 1'b0;
    m_axi_rlast      = 1'b0;
    m_axi_rresp      = 2'b00;
    m_axi_rdata      = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy",    dram_read_busy,       1'b0);
    chk("rst_valid",   dram_read_data_valid, 1'b0);
    chk("rst_data",    dram_read_data,       128'h0);
    chk("rst_error",   dram_read_error,      1'b0);
    chk("rst_arvalid", m_axi_arvalid,        1'b0);
    chk("rst_araddr",  m_axi_araddr,         39'h0);
    chk("rst_arlen",   m_axi_arlen,          8'h0);
    chk("rst_rready",  m_axi_rready,         1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // T1: aligned 4-beat request
    clear_obs();
    issue(39'h0000_1000, 8'd3);
    chk("t1_busy",    dram_read_busy, 1'b1);
    chk("t1_arvalid", m_axi_arvalid,  1'b1);
    chk("t1_araddr",  m_axi_araddr,   39'h1000);
    chk("t1_arlen",   m_axi_arlen,    8'd3);
    chk("t1_arsize",  m_axi_arsize,   3'b100);
    chk("t1_arburst", m_axi_arburst,  2'b01);
    wait_done(100);
    chk("t1_ar_cnt",  obs_araddr.size(), 1);
    chk("t1_beats",   obs_data.size(), 4);
    chk("t1_d0", obs_data[0], 128'h1000);
    chk("t1_d1", obs_data[1], 128'h1010);
    chk("t1_d2", obs_data[2], 128'h1020);
    chk("t1_d3", obs_data[3], 128'h1030);
    chk("t1_busy_fall", fall_cyc, obs_cyc[3]);
    chk("t1_error", dram_read_error, 1'b0);

    // T2: request straddling a 4 KB boundary
    clear_obs();
    issue(39'h0000_0FF0, 8'd3);
    wait_done(100);
    chk("t2_ar_cnt", obs_araddr.size(), 2);
    chk("t2_ar0_addr", obs_araddr[0], 39'h0FF0);
    chk("t2_ar0_len",  obs_arlen[0],  8'd0);
    chk("t2_ar1_addr", obs_araddr[1], 39'h1000);
    chk("t2_ar1_len",  obs_arlen[1],  8'd2);
    chk("t2_beats", obs_data.size(), 4);
    chk("t2_d0", obs_data[0], 128'h0FF0);
    chk("t2_d1", obs_data[1], 128'h1000);
    chk("t2_d3", obs_data[3], 128'h1020);
    chk("t2_error", dram_read_error, 1'b0);

    // T3: consumer back-pressure for 5 cycles mid-burst
    clear_obs();
    issue(39'h0000_2000, 8'd7);
    wait_valids(2, 50);
    @(posedge clk); #1;
    dram_buffer_full = 1'b1;
    base = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk($sformatf("t3_rready_c%0d", i), m_axi_rready, 1'b0);
      if (i == 0) base = obs_data.size();
    end
    chk("t3_no_valid_stalled", obs_data.size(), base);
    @(posedge clk); #1;
    dram_buffer_full = 1'b0;
    wait_done(100);
    chk("t3_beats", obs_data.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t3_d%0d", i), obs_data[i], 128'(39'h2000 + 39'(i * 16)));
    end

    // T4: SLVERR on the second beat, error sticky afterwards
    clear_obs();
    inj_err_beat = 1;
    issue(39'h0000_3000, 8'd3);
    wait_done(100);
    inj_err_beat = -1;
    chk("t4_beats", obs_data.size(), 4);
    chk("t4_d3", obs_data[3], 128'h3030);
    chk("t4_error", dram_read_error, 1'b1);
    repeat (3) @(negedge clk);
    chk("t4_error_sticky", dram_read_error, 1'b1);

    // T5: early rlast, and a request strobe while busy is ignored
    clear_obs();
    inj_rlast_beat = 1;
    issue(39'h0000_3400, 8'd3);
    chk("t5_error_cleared", dram_read_error, 1'b0);
    @(posedge clk); #1;
    dram_read_addr = 39'h7000;
    dram_read_len  = 8'd0;
    dram_read_en   = 1'b1;
    @(posedge clk); #1;
    dram_read_en   = 1'b0;
    wait_done(100);
    inj_rlast_beat = -1;
    repeat (3) @(negedge clk);
    chk("t5_ar_cnt",  obs_araddr.size(), 1);
    chk("t5_ar_addr", obs_araddr[0], 39'h3400);
    chk("t5_beats",   obs_data.size(), 4);
    chk("t5_error",   dram_read_error, 1'b1);
    chk("t5_busy",    dram_read_busy, 1'b0);

    // T6: reset asserted during DATA, then a clean request
    clear_obs();
    issue(39'h0000_4000, 8'd15);
    wait_valids(2, 50);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("t6_busy",    dram_read_busy,       1'b0);
    chk("t6_valid",   dram_read_data_valid, 1'b0);
    chk("t6_data",    dram_read_data,       128'h0);
    chk("t6_error",   dram_read_error,      1'b0);
    chk("t6_arvalid", m_axi_arvalid,        1'b0);
    chk("t6_araddr",  m_axi_araddr,         39'h0);
    chk("t6_arlen",   m_axi_arlen,          8'h0);
    chk("t6_rready",  m_axi_rready,         1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_obs();
    issue(39'h0000_5000, 8'd1);
    wait_done(100);
    chk("t6b_ar_cnt",  obs_araddr.size(), 1);
    chk("t6b_ar_addr", obs_araddr[0], 39'h5000);
    chk("t6b_ar_len",  obs_arlen[0],  8'd1);
    chk("t6b_beats",   obs_data.size(), 2);
    chk("t6b_d0", obs_data[0], 128'h5000);
    chk("t6b_d1", obs_data[1], 128'h5010);
    chk("t6b_error", dram_read_error, 1'b0);

    // T7: 256 beats from an aligned 4 KB address is a single burst;
    // the unaligned low nibble of the address is ignored
    clear_obs();
    issue(39'h0000_8007, 8'd255);
    chk("t7_araddr", m_axi_araddr, 39'h8000);
    chk("t7_arlen",  m_axi_arlen,  8'd255);
    wait_done(400);
    chk("t7_ar_cnt", obs_araddr.size(), 1);
    chk("t7_beats",  obs_data.size(), 256);
    chk("t7_d0",     obs_data[0],   128'h8000);
    chk("t7_d255",   obs_data[255], 128'h8FF0);
    chk("t7_error",  dram_read_error, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dram_burst_reader.md
# dram_burst_reader

AXI4 read master between the image controller's DRAM request interface and the PS DDR port. It accepts a single-pulse request (address plus beat count), splits it at 4 KB boundaries into legal INCR bursts, and issues them on the AR channel. It returns 128-bit beats to the image controller with back-pressure from the consumer's buffer, and reports busy and error status.

## Interface
- DRAM_ADDR_WIDTH, 39: byte address width of DRAM and AXI.
- DRAM_DATA_WIDTH, 128: data width; beat size = 16 bytes, arsize fixed 3'b100.
- s_axi_aclk  in  1  sole clock.
- s_axi_aresetn  in  1  reset; asynchronous, active-low.
- dram_read_addr  in  DRAM_ADDR_WIDTH  request start byte address; bits [3:0] ignored (treated as 0).
- dram_read_len  in  8  request beats minus one (0..255).
- dram_read_en  in  1  one-cycle request strobe.
- dram_buffer_full  in  1  consumer cannot take data; stalls rready.
- dram_read_busy  out  1  request in progress.
- dram_read_data  out  DRAM_DATA_WIDTH  returned beat.
- dram_read_data_valid  out  1  one-cycle qualifier for dram_read_data.
- dram_read_error  out  1  sticky: any rresp != OKAY or rlast mismatch in the current request.
- m_axi_araddr  out  DRAM_ADDR_WIDTH; m_axi_arlen  out  8; m_axi_arsize  out  3 (3'b100); m_axi_arburst  out  2 (2'b01 INCR); m_axi_arvalid  out  1; m_axi_arready  in  1.
- m_axi_rdata  in  DRAM_DATA_WIDTH; m_axi_rresp  in  2; m_axi_rlast  in  1; m_axi_rvalid  in  1; m_axi_rready  out  1.

## Operation
- States: IDLE, ADDR, DATA.
- IDLE: on dram_read_en, latch aligned address and total = len+1 (9-bit), set busy, clear error, go ADDR. dram_read_en is ignored outside IDLE.
- ADDR: room = 256 − addr[11:4] (9-bit). burst = min(total, room). Drive arlen = burst−1 and arvalid. On arvalid&arready: addr += burst×16, total −= burst, beat counter = burst−1, go DATA.
- DATA: rready = ~dram_buffer_full. On rvalid&rready: register rdata into dram_read_data and pulse valid. Error if rresp != 2'b00, or if rlast disagrees with (beat counter == 0). Decrement counter. On the last beat: go ADDR if total != 0, else IDLE and drop busy.
- Reset values: busy 0, data 0, valid 0, error 0, arvalid 0, araddr 0, arlen 0, rready 0, state IDLE.
- Reset mid-request abandons the transaction with no drain. The interconnect is reset by the same reset.

## Timing
- busy and arvalid rise the cycle after dram_read_en.
- arvalid, araddr and arlen are registered and held stable until arready.
- Exactly one burst is outstanding; AR for the next split is issued the cycle after the previous burst's last beat.
- Data latency: dram_read_data_valid is asserted one cycle after each rvalid&rready.
- rready is combinational from dram_buffer_full and the state. The consumer must raise full with at least one beat of slack.
- busy falls the cycle after the final beat handshake. A new dram_read_en is accepted in that same cycle busy reads 0.
- A request of 256 beats starting at an aligned 4 KB address issues a single burst with arlen = 255.

## Structure
- A shared package holds the AXI constants (BURST_INCR, RESP_OKAY, ARSIZE_16B) and the state enum typedef.
- Implement as a single module with no sub-modules. The 4 KB split arithmetic is a local function.

## Test plan
- addr 0x0000_1000, len 3, arready immediate -> one AR (0x1000, arlen 3); four valid pulses with data in order; busy low 1 cycle after the 4th beat; error 0.
- addr 0x0FF0, len 3 -> AR (0x0FF0, arlen 0), then AR (0x1000, arlen 2); 4 beats total.
- dram_buffer_full held high for 5 cycles mid-burst -> rready 0 for those cycles; no valid pulses; no beat lost or duplicated.
- 2nd beat of a 4-beat burst returns rresp 2'b10 -> error sets and stays 1 until the next accepted request; all 4 beats still delivered.
- dram_read_en pulsed while busy -> ignored, so no extra AR is issued; rlast asserted on beat 2 of a 4-beat burst -> error 1.
- aresetn asserted during DATA -> all outputs return to reset values immediately; a subsequent request completes normally.
